// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the FSM state encoding and the divide-by-zero quotient pattern.
package divider_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t DONE = 2'd2;

  // Divide-by-zero quotient: all ones, sliced to WIDTH by the user (max 64).
  localparam logic [63:0] DBZ_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor at WIDTH+1 bits, keep the result if non-negative.
module div_step
  import divider_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Trial subtract; MSB of the WIDTH+1 difference is the borrow.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/divider_seq.sv
// Sequential restoring divider, fixed latency WIDTH+1 cycles (1 for /0).
// Optional macro DIVIDER_SIGNED_EN: two's-complement truncating division
// wrapped around the same unsigned core.
module divider_seq
  import divider_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd_sh;   // dividend magnitude, consumed MSB first
  logic [WIDTH-1:0] dvs;      // divisor magnitude
  logic [WIDTH-1:0] rem_acc;
  logic [WIDTH-1:0] quo_acc;
  logic [WIDTH-1:0] rem_nxt;
  logic             q_bit;
  logic [WIDTH-1:0] quo_fin;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;

`ifdef DIVIDER_SIGNED_EN
  logic neg_q;
  logic neg_r;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_acc),
    .bit_in  (dvd_sh[WIDTH-1]),
    .divisor (dvs),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  assign quo_fin = {quo_acc[WIDTH-2:0], q_bit};

  // Operand magnitudes at accept and sign fix-up of the final step's result.
  always_comb begin
    dvd_mag = dividend;
    dvs_mag = divisor;
    q_res   = quo_fin;
    r_res   = rem_nxt;
`ifdef DIVIDER_SIGNED_EN
    if (dividend[WIDTH-1]) dvd_mag = -dividend;
    if (divisor[WIDTH-1])  dvs_mag = -divisor;
    if (neg_q) q_res = -quo_fin;
    if (neg_r) r_res = -rem_nxt;
`endif
  end

  // FSM, iteration datapath and registered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd_sh      <= '0;
      dvs         <= '0;
      rem_acc     <= '0;
      quo_acc     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              quotient    <= DBZ_QUOT[WIDTH-1:0];
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              dvd_sh  <= dvd_mag;
              dvs     <= dvs_mag;
              rem_acc <= '0;
              quo_acc <= '0;
              cnt     <= '0;
`ifdef DIVIDER_SIGNED_EN
              neg_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              neg_r   <= dividend[WIDTH-1];
`endif
              state   <= CALC;
            end
          end
        end
        CALC: begin
          dvd_sh  <= dvd_sh << 1;
          rem_acc <= rem_nxt;
          quo_acc <= quo_fin;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            quotient    <= q_res;
            remainder   <= r_res;
            div_by_zero <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq at WIDTH=8: directed table,
// handshake/reset corner sequences and randomized ops against an arithmetic model.
module tb_divider_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  divider_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the operands' numeric values.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
      z = 1'b0;
`ifdef DIVIDER_SIGNED_EN
      begin
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        q = W'(sa / sb);
        r = W'(sa % sb);
      end
`else
      q = a / b;
      r = a % b;
`endif
    end
  endtask

  // Issue one op from IDLE (#1 after a posedge), wait bounded for the result,
  // then hand it off. Latency counts the accept cycle as 1.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic z, output int lat);
    logic [W-1:0] prev_q;
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    prev_q    = quotient;
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    if (b != 0) chk("hold_prev_in_calc", quotient, prev_q);
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_drop_after_handoff", out_valid, 0);
  endtask

  vec_t tbl[8];

  initial begin
    logic [W-1:0] q, r, eq, er;
    logic         z, ez;
    int           lat;
    bit           seen;

`ifdef DIVIDER_SIGNED_EN
    tbl[0] = '{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 9};  // -7/2
    tbl[1] = '{8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 9};  // 7/-2
    tbl[2] = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 9};  // MIN/-1 wraps
    tbl[3] = '{8'h05, 8'h00, 8'hFF, 8'h05, 1'b1, 1};  // 5/0
    tbl[4] = '{8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b1, 1};  // -5/0
    tbl[5] = '{8'hC8, 8'h07, 8'hF8, 8'h00, 1'b0, 9};  // -56/7
    tbl[6] = '{8'h80, 8'h7F, 8'hFF, 8'hFF, 1'b0, 9};  // -128/127
    tbl[7] = '{8'h64, 8'h09, 8'h0B, 8'h01, 1'b0, 9};  // 100/9
`else
    tbl[0] = '{8'd200, 8'd7,   8'd28,  8'd4, 1'b0, 9};
    tbl[1] = '{8'd5,   8'd0,   8'hFF,  8'd5, 1'b1, 1};
    tbl[2] = '{8'd0,   8'd5,   8'd0,   8'd0, 1'b0, 9};
    tbl[3] = '{8'd255, 8'd1,   8'd255, 8'd0, 1'b0, 9};
    tbl[4] = '{8'd255, 8'd255, 8'd1,   8'd0, 1'b0, 9};
    tbl[5] = '{8'd1,   8'd255, 8'd0,   8'd1, 1'b0, 9};
    tbl[6] = '{8'd128, 8'd16,  8'd8,   8'd0, 1'b0, 9};
    tbl[7] = '{8'd0,   8'd0,   8'hFF,  8'd0, 1'b1, 1};
`endif

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, q, r, z, lat);
      chk($sformatf("tbl%0d_q", i), q, tbl[i].q);
      chk($sformatf("tbl%0d_r", i), r, tbl[i].r);
      chk($sformatf("tbl%0d_z", i), z, tbl[i].z);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
    end

    // Back-pressure in DONE with a competing request pending: 100/9 then 33/4
    run_op(8'd100, 8'd9, q, r, z, lat);  // leaves IDLE, result 11 r 1 captured
    dividend = 8'd100; divisor = 8'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("bp_lat", lat, 9);
    in_valid = 1'b1; dividend = 8'd33; divisor = 8'd4;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_q_stable", quotient, 8'd11);
      chk("bp_r_stable", remainder, 8'd1);
      chk("bp_valid_held", out_valid, 1);
      chk("bp_in_ready_low", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_handoff_in_ready", in_ready, 1);
    chk("bp_handoff_valid", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accept_next", in_ready, 0);
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("bp2_lat", lat, 9);
    chk("bp2_q", quotient, 8'd8);
    chk("bp2_r", remainder, 8'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of CALC (step 3 of 255/1)
    dividend = 8'd255; divisor = 8'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_q", quotient, 0);
    chk("midrst_r", remainder, 0);
    chk("midrst_dbz", div_by_zero, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_result", seen, 0);
    run_op(8'd9, 8'd3, q, r, z, lat);
    chk("post_rst_q", q, 8'd3);
    chk("post_rst_r", r, 8'd0);
    chk("post_rst_lat", lat, 9);

    // Randomized ops against the model
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      if (i == 0) begin a = 8'h80; b = 8'hFF; end
      model(a, b, eq, er, ez);
      run_op(a, b, q, r, z, lat);
      chk($sformatf("rnd%0d_q %0h/%0h", i, a, b), q, eq);
      chk($sformatf("rnd%0d_r %0h/%0h", i, a, b), r, er);
      chk($sformatf("rnd%0d_z", i), z, ez);
      chk($sformatf("rnd%0d_lat", i), lat, ez ? 1 : W + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/divider_seq.md
DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/result width in bits (legal range 4..64).
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operands present on dividend/divisor.
REQ-005 SHALL have port in_ready  output  1  block can accept a new operation.
REQ-006 SHALL have ports dividend and divisor, both input  WIDTH  operands.
REQ-007 SHALL have port out_valid  output  1  result present on quotient/remainder/div_by_zero.
REQ-008 SHALL have port out_ready  input  1  consumer takes the result.
REQ-009 SHALL have ports quotient and remainder, both output  WIDTH  result, with dividend = divisor*quotient + remainder.
REQ-010 SHALL have port div_by_zero  output  1  registered result flag: divisor was zero.

Function
REQ-011 SHALL implement states IDLE, CALC and DONE; in_ready SHALL equal (state==IDLE).
REQ-012 SHALL accept an operation on a clk edge with in_valid&&in_ready, registering both operands; operands at any other time SHALL be ignored.
REQ-013 SHALL move IDLE->CALC on accept when divisor!=0, and IDLE->DONE on accept when divisor==0.
REQ-014 SHALL, in CALC, do one restoring step per cycle (shift partial remainder left by one and bring in the next dividend bit, MSB first; trial-subtract divisor at WIDTH+1 bits; keep the result if non-negative; shift the quotient bit in).
REQ-015 SHALL count CALC steps with a counter of $clog2(WIDTH+1) bits, and leave CALC for DONE after exactly WIDTH steps.
REQ-016 SHALL use a fixed latency: out_valid rises WIDTH+1 cycles after the accept edge for divisor!=0, and 1 cycle after it for divisor==0, with no early termination.
REQ-017 SHALL, for divide-by-zero, produce quotient = all ones, remainder = dividend and div_by_zero=1; otherwise div_by_zero=0.
REQ-018 SHALL assert out_valid only in DONE and hold quotient/remainder/div_by_zero stable while out_valid&&!out_ready.
REQ-019 SHALL go DONE->IDLE on the edge where out_valid&&out_ready; in_ready SHALL rise the following cycle, so there is no accept in the same cycle as result handoff.
REQ-020 SHALL not register any output changes during CALC; outputs SHALL keep the previous result until DONE is entered.

Reset
REQ-021 SHALL, on rst=1, force state=IDLE, counter=0, quotient=0, remainder=0, div_by_zero=0 and out_valid=0 asynchronously, with in_ready=1 once the state reaches IDLE.
REQ-022 SHALL discard any in-flight operation when rst asserts mid-CALC or in DONE, with no result emitted.

Configuration
REQ-023 SHALL have macro DIVIDER_SIGNED_EN; when undefined, operands and results are unsigned.
REQ-024 SHALL, with DIVIDER_SIGNED_EN defined, treat operands as two's complement and capture their magnitudes at accept; the unsigned core is unchanged.
REQ-025 SHALL, with DIVIDER_SIGNED_EN defined, negate the quotient when the operand signs differ and give the remainder the dividend's sign (truncating division), applied on CALC->DONE.
REQ-026 SHALL, with DIVIDER_SIGNED_EN defined, give MIN/-1 the result quotient=MIN, remainder=0 (natural wrap); divide-by-zero returns quotient=-1 and remainder=dividend.

Structure
REQ-027 SHALL place the state enum (IDLE/CALC/DONE) and the divide-by-zero quotient constant in shared package divider_pkg.
REQ-028 SHALL put the single restoring iteration in a combinational sub-module div_step, parameterised by WIDTH.

Verification (WIDTH=8)
REQ-029 SHALL check unsigned 200/7: quotient=28, remainder=4, div_by_zero=0, out_valid exactly 9 cycles after accept.
REQ-030 SHALL check 5/0: quotient=0xFF, remainder=5, div_by_zero=1, out_valid 1 cycle after accept.
REQ-031 SHALL check out_ready held low 5 cycles in DONE with in_valid=1 and new operands: outputs stable, in_ready=0, no accept; accept occurs the cycle after out_ready.
REQ-032 SHALL check rst pulsed at CALC step 3 of 255/1: outputs zero, out_valid never rises, then 9/3 completes with quotient=3, remainder=0.
REQ-033 SHALL check, with DIVIDER_SIGNED_EN: -7/2 gives quotient=-3, remainder=-1; 7/-2 gives quotient=-3, remainder=1; -128/-1 gives quotient=-128, remainder=0.
